branch_ctrl: RTL and testbench

//  Branch resolution and recovery controller for the pipelined RISC-V core.

---
 rtl/branch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_branch_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution at EX, mispredict recovery sequencing and the
// 2-bit-counter BHT that feeds the IF-stage prediction.
module branch_ctrl #(
   parameter int BHT_ENTRIES  = 64,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_pc,
   output logic        if_pred_taken,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic        ex_is_jump,
   input  logic [2:0]  ex_f3,
   input  logic [5:0]  ex_branches,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_target,
   output logic        redirect_valid,
   input  logic        redirect_ready,
   output logic [31:0] redirect_pc,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        busy,
   output logic        branch_err,
   output logic [31:0] perf_branches,
   output logic [31:0] perf_mispred
);

   localparam int IW = $clog2(BHT_ENTRIES);
   localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

   typedef enum logic [1:0] {
      S_RUN,
      S_REDIRECT,
      S_FLUSH
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     rpc_q, rpc_d;
   logic [31:0]     pbr_q, pbr_d;
   logic [31:0]     pmis_q, pmis_d;
   logic [1:0]      bht_q [BHT_ENTRIES];

   logic            resolve;
   logic            br_taken;
   logic            f3_bad;
   logic            taken;
   logic            mispredict;
   logic            bht_we;
   logic [IW-1:0]   ex_idx;
   logic [IW-1:0]   if_idx;
   logic [1:0]      bht_old;
   logic [1:0]      bht_new;
   logic            unused_pc_bits;

   assign if_idx = if_pc[IW+1:2];
   assign ex_idx = ex_pc[IW+1:2];
   assign unused_pc_bits = ^{if_pc[31:IW+2], if_pc[1:0]};

   assign if_pred_taken = bht_q[if_idx][1];

   always_comb begin
      br_taken = 1'b0;
      f3_bad   = 1'b0;
      unique case (ex_f3)
         BR_BEQ:  br_taken = ex_branches[0];
         BR_BNE:  br_taken = ex_branches[1];
         BR_BLT:  br_taken = ex_branches[2];
         BR_BGE:  br_taken = ex_branches[3];
         BR_BLTU: br_taken = ex_branches[4];
         BR_BGEU: br_taken = ex_branches[5];
         default: f3_bad   = 1'b1;
      endcase
   end

   assign resolve    = (state_q == S_RUN) & ex_valid & (ex_is_branch | ex_is_jump);
   assign taken      = ex_is_jump | br_taken;
   assign mispredict = resolve & (taken != ex_pred_taken);
   assign branch_err = resolve & ~ex_is_jump & f3_bad;
   assign bht_we     = resolve & ~ex_is_jump & ~f3_bad;

   always_comb begin
      bht_old = bht_q[ex_idx];
      bht_new = bht_old;
      if (br_taken) begin
         if (bht_old != 2'b11) bht_new = bht_old + 2'b01;
      end else begin
         if (bht_old != 2'b00) bht_new = bht_old - 2'b01;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      rpc_d          = rpc_q;
      redirect_valid = 1'b0;
      flush_if_id    = 1'b0;
      unique case (state_q)
         S_RUN: begin
            if (mispredict) begin
               state_d = S_REDIRECT;
               rpc_d   = taken ? ex_target : ex_pc + 32'd4;
            end
         end
         S_REDIRECT: begin
            redirect_valid = 1'b1;
            flush_if_id    = 1'b1;
            if (redirect_ready) begin
               state_d = S_FLUSH;
               cnt_d   = CNT_INIT;
            end
         end
         S_FLUSH: begin
            flush_if_id = 1'b1;
            if (cnt_q == '0) state_d = S_RUN;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = S_RUN;
      endcase
   end

   assign flush_id_ex = flush_if_id;
   assign busy        = (state_q != S_RUN);
   assign redirect_pc = rpc_q;

   // Perf counters stick at all-ones instead of wrapping.
   always_comb begin
      pbr_d  = pbr_q;
      pmis_d = pmis_q;
      if (resolve && pbr_q != 32'hFFFF_FFFF)     pbr_d  = pbr_q + 32'd1;
      if (mispredict && pmis_q != 32'hFFFF_FFFF) pmis_d = pmis_q + 32'd1;
   end

   assign perf_branches = pbr_q;
   assign perf_mispred  = pmis_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         cnt_q   <= '0;
         rpc_q   <= '0;
         pbr_q   <= '0;
         pmis_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rpc_q   <= rpc_d;
         pbr_q   <= pbr_d;
         pmis_q  <= pmis_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      end else if (bht_we) begin
         bht_q[ex_idx] <= bht_new;
      end
   end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: resolution, BHT training,
// redirect/flush sequencing, wrap-around, bad f3 and async reset.
module tb_branch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic        ex_valid;
   logic        ex_is_branch;
   logic        ex_is_jump;
   logic [2:0]  ex_f3;
   logic [5:0]  ex_branches;
   logic        ex_pred_taken;
   logic [31:0] ex_pc;
   logic [31:0] ex_target;
   logic        redirect_valid;
   logic        redirect_ready;
   logic [31:0] redirect_pc;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        busy;
   logic        branch_err;
   logic [31:0] perf_branches;
   logic [31:0] perf_mispred;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 clk = ~clk;

   branch_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .if_pc          (if_pc),
      .if_pred_taken  (if_pred_taken),
      .ex_valid       (ex_valid),
      .ex_is_branch   (ex_is_branch),
      .ex_is_jump     (ex_is_jump),
      .ex_f3          (ex_f3),
      .ex_branches    (ex_branches),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pc          (ex_pc),
      .ex_target      (ex_target),
      .redirect_valid (redirect_valid),
      .redirect_ready (redirect_ready),
      .redirect_pc    (redirect_pc),
      .flush_if_id    (flush_if_id),
      .flush_id_ex    (flush_id_ex),
      .busy           (busy),
      .branch_err     (branch_err),
      .perf_branches  (perf_branches),
      .perf_mispred   (perf_mispred)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic ex_drive(input logic v, input logic b, input logic j,
                           input logic [2:0] f3, input logic [5:0] br,
                           input logic p, input logic [31:0] pc,
                           input logic [31:0] tgt);
      ex_valid      = v;
      ex_is_branch  = b;
      ex_is_jump    = j;
      ex_f3         = f3;
      ex_branches   = br;
      ex_pred_taken = p;
      ex_pc         = pc;
      ex_target     = tgt;
   endtask

   task automatic ex_idle();
      ex_drive(0, 0, 0, 3'b000, 6'b0, 0, 32'h0, 32'h0);
   endtask

   // Called at a negedge one cycle after a mispredict; drains recovery.
   task automatic recover();
      int g;
      g = 0;
      ex_idle();
      redirect_ready = 1'b1;
      #1;
      while (busy && g < 20) begin
         @(negedge clk);
         #1;
         g++;
      end
      check("recover_timeout", {31'b0, busy}, 32'd0);
      redirect_ready = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      if_pc          = 32'h0;
      redirect_ready = 1'b0;
      ex_idle();
      #1;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_rv", {31'b0, redirect_valid}, 32'd0);
      check("rst_rpc", redirect_pc, 32'd0);
      check("rst_flush", {30'b0, flush_if_id, flush_id_ex}, 32'd0);
      check("rst_pbr", perf_branches, 32'd0);
      check("rst_pmis", perf_mispred, 32'd0);
      check("rst_err", {31'b0, branch_err}, 32'd0);
      for (int i = 0; i < 64; i++) begin
         if_pc = 32'(i) << 2;
         #1;
         check("rst_pred", {31'b0, if_pred_taken}, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // BEQ taken, predicted not-taken
      @(negedge clk);
      ex_drive(1, 1, 0, 3'b000, 6'b000001, 0, 32'h100, 32'h80);
      #1;
      check("beq_rv_early", {31'b0, redirect_valid}, 32'd0);
      check("beq_err", {31'b0, branch_err}, 32'd0);
      @(negedge clk);
      ex_idle();
      redirect_ready = 1'b1;
      if_pc = 32'h100;
      #1;
      check("beq_rv", {31'b0, redirect_valid}, 32'd1);
      check("beq_rpc", redirect_pc, 32'h80);
      check("beq_busy", {31'b0, busy}, 32'd1);
      check("beq_fid", {31'b0, flush_id_ex}, 32'd1);
      check("beq_pmis", perf_mispred, 32'd1);
      check("beq_pbr", perf_branches, 32'd1);
      check("beq_bht", {31'b0, if_pred_taken}, 32'd1);
      n = 0;
      while (flush_if_id && n < 20) begin
         n++;
         @(negedge clk);
         #1;
      end
      check("beq_flush_len", n, 32'd3);
      check("beq_busy_end", {31'b0, busy}, 32'd0);
      redirect_ready = 1'b0;

      // BNE not taken x3, idx 1 saturates at 00
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ex_drive(1, 1, 0, 3'b001, 6'b111101, 0, 32'h204, 32'h40);
         #1;
         check("bne_rv", {31'b0, redirect_valid | busy}, 32'd0);
      end
      @(negedge clk);
      ex_idle();
      if_pc = 32'h204;
      #1;
      check("bne_pbr", perf_branches, 32'd4);
      check("bne_pmis", perf_mispred, 32'd1);
      check("bne_pred", {31'b0, if_pred_taken}, 32'd0);
      ex_drive(1, 1, 0, 3'b001, 6'b000010, 0, 32'h204, 32'h40);
      @(negedge clk);
      #1;
      check("bne_t_rpc", redirect_pc, 32'h40);
      recover();
      check("bne_sat", {31'b0, if_pred_taken}, 32'd0);
      check("bne_t_pbr", perf_branches, 32'd5);
      check("bne_t_pmis", perf_mispred, 32'd2);

      // BGE taken mispredict, ready withheld 4 cycles
      @(negedge clk);
      ex_drive(1, 1, 0, 3'b101, 6'b001000, 0, 32'h300, 32'h1234);
      @(negedge clk);
      ex_drive(1, 1, 0, 3'b010, 6'b111111, 1, 32'h500, 32'h600);
      #1;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         check("wait_rv", {31'b0, redirect_valid}, 32'd1);
         check("wait_rpc", redirect_pc, 32'h1234);
         check("wait_err", {31'b0, branch_err}, 32'd0);
         if (flush_if_id) n++;
         @(negedge clk);
         #1;
      end
      redirect_ready = 1'b1;
      while (flush_if_id && n < 20) begin
         n++;
         @(negedge clk);
         #1;
      end
      redirect_ready = 1'b0;
      ex_idle();
      check("wait_flush_len", n, 32'd7);
      check("wait_pbr", perf_branches, 32'd6);
      check("wait_pmis", perf_mispred, 32'd3);

      // BLT predicted taken, falls through at top of memory
      @(negedge clk);
      ex_drive(1, 1, 0, 3'b100, 6'b111011, 1, 32'hFFFF_FFFC, 32'h10);
      @(negedge clk);
      #1;
      check("wrap_rv", {31'b0, redirect_valid}, 32'd1);
      check("wrap_rpc", redirect_pc, 32'h0);
      recover();

      // Bad funct3 on a branch
      @(negedge clk);
      if_pc = 32'h108;
      ex_drive(1, 1, 0, 3'b010, 6'b111111, 0, 32'h108, 32'h0);
      #1;
      check("err_pulse", {31'b0, branch_err}, 32'd1);
      @(negedge clk);
      ex_idle();
      #1;
      check("err_clear", {31'b0, branch_err}, 32'd0);
      check("err_busy", {31'b0, busy}, 32'd0);
      check("err_pbr", perf_branches, 32'd8);
      check("err_pmis", perf_mispred, 32'd4);
      check("err_bht", {31'b0, if_pred_taken}, 32'd0);

      // Jump with bogus f3 takes priority, then reset in REDIRECT
      @(negedge clk);
      ex_drive(1, 1, 1, 3'b011, 6'b000000, 0, 32'h400, 32'h500);
      #1;
      check("jmp_err", {31'b0, branch_err}, 32'd0);
      @(negedge clk);
      ex_idle();
      if_pc = 32'h100;
      #1;
      check("jmp_rpc", redirect_pc, 32'h500);
      check("jmp_rv", {31'b0, redirect_valid}, 32'd1);
      check("pre_rst_bht", {31'b0, if_pred_taken}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_rv", {31'b0, redirect_valid}, 32'd0);
      check("arst_busy", {31'b0, busy}, 32'd0);
      check("arst_flush", {30'b0, flush_if_id, flush_id_ex}, 32'd0);
      check("arst_rpc", redirect_pc, 32'd0);
      check("arst_pbr", perf_branches, 32'd0);
      check("arst_pmis", perf_mispred, 32'd0);
      check("arst_bht", {31'b0, if_pred_taken}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("post_rst_rv", {31'b0, redirect_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
